integer_divider: RTL and testbench

- Iterative radix-2 restoring integer divider; the inverse of the core's pipelined integer multiplier.
- Sits beside the multiplier in the integer execute path.
- Accepts one operation per start/done handshake and returns quotient and remainder.
- Non-pipelined: one operation in flight at a time.

---
 rtl/integer_divider_pkg.sv | 15 +
 rtl/integer_divider_step.sv | 18 +
 rtl/integer_divider.sv | 132 +++++++++++++
 tb/tb_integer_divider.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/integer_divider_pkg.sv
// integer_divider_pkg: shared FSM encoding, latency and divide-by-zero result constants.
// Also consumed by the execute-stage bypass logic.
package integer_divider_pkg;
    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 2;
    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ITERATE,
        DIV_FIXUP,
        DIV_DONE
    } div_state_e;
    // A zero divisor yields an all-ones quotient and the raw dividend as remainder.
    localparam logic DIV_DBZ_QUOTIENT_BIT = 1'b1;
    localparam logic DIV_DBZ_FLAG         = 1'b1;
endpackage

// File: rtl/integer_divider_step.sv
// integer_divider_step: one restoring-division step on a WIDTH+1 bit partial remainder.
module integer_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] den_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, den_i};
    assign q_o     = ~diff[WIDTH];
    // rem_i < den_i keeps both the kept difference and the restored value within WIDTH bits.
    assign rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/integer_divider.sv
// integer_divider: iterative radix-2 restoring divider, one operation in flight.
// INTEGER_DIVIDER_ZERO_FAST_EN: a zero divisor skips straight from IDLE to DONE.
module integer_divider
    import integer_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbzo_q, dbzo_d;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    integer_divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .bit_i (num_q[WIDTH-1]),
        .den_i (den_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            remo_q  <= '0;
            dbzo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dbz_q   <= dbz_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            dbzo_q  <= dbzo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        den_d   = den_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dbz_d   = dbz_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        dbzo_d  = dbzo_q;
        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    num_d   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
                    den_d   = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
                    dvd_d   = dividend;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    negq_d  = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    negr_d  = is_signed && dividend[WIDTH-1];
                    dbz_d   = (divisor == '0);
                    state_d = DIV_ITERATE;
`ifdef INTEGER_DIVIDER_ZERO_FAST_EN
                    if (divisor == '0) begin
                        quo_d   = {WIDTH{DIV_DBZ_QUOTIENT_BIT}};
                        remo_d  = dividend;
                        dbzo_d  = DIV_DBZ_FLAG;
                        state_d = DIV_DONE;
                    end
`endif
                end
            end
            DIV_ITERATE: begin
                // Dividend bits shift out the top while quotient bits fill in from the bottom.
                rem_d   = step_rem;
                num_d   = {num_q[WIDTH-2:0], step_q};
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == '0) ? DIV_FIXUP : DIV_ITERATE;
            end
            DIV_FIXUP: begin
                quo_d   = dbz_q ? {WIDTH{DIV_DBZ_QUOTIENT_BIT}} : (negq_q ? -num_q : num_q);
                remo_d  = dbz_q ? dvd_q : (negr_q ? -rem_q : rem_q);
                dbzo_d  = dbz_q;
                state_d = DIV_DONE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    assign busy        = (state_q != DIV_IDLE);
    assign done        = (state_q == DIV_DONE);
    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbzo_q;
endmodule

// File: tb/tb_integer_divider.sv
// tb_integer_divider: directed and randomized checks of integer_divider against an arithmetic model.
module tb_integer_divider;
    localparam int W   = 32;
    localparam int LAT = W + 2;
`ifdef INTEGER_DIVIDER_ZERO_FAST_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic         clk, reset, start, is_signed, busy, done, div_by_zero;
    logic [W-1:0] dividend, divisor, quotient, remainder;
    int           n_checks = 0;
    int           n_fail = 0;
    time          t_acc;

    integer_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit poke);
        logic [W-1:0] eq, er;
        logic         ez;
        int           lat, nbusy, exp_lat;
        ref_div(s, a, b, eq, er, ez);
        exp_lat = (b == '0 && ZF) ? 1 : LAT;
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        start = 1'b1;
        is_signed = s;
        dividend = a;
        divisor = b;
        @(posedge clk);
        t_acc = $time;
        #1;
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        is_signed = ~s;
        lat = 0;
        nbusy = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 9) begin
                start = 1'b1;
                dividend = 50;
                divisor = 5;
            end
            if (poke && lat == 10) start = 1'b0;
            if (busy) nbusy++;
            if (done) break;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, nbusy, exp_lat);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, ez);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_idle_after"}, busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b;
        time          prev;
        reset = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        run_op("u100_7", 1'b0, 100, 7, 1'b0);
        check("u100_7_q_const", quotient, 14);
        check("u100_7_r_const", remainder, 2);
        run_op("s_m7_2", 1'b1, -7, 2, 1'b0);
        check("s_m7_2_q_const", quotient, 32'hFFFF_FFFD);
        check("s_m7_2_r_const", remainder, 32'hFFFF_FFFF);
        run_op("s_7_m2", 1'b1, 7, -2, 1'b0);
        check("s_7_m2_r_const", remainder, 1);
        run_op("u_dbz", 1'b0, 32'h1234_5678, 0, 1'b0);
        check("u_dbz_q_const", quotient, 32'hFFFF_FFFF);
        run_op("s_dbz", 1'b1, -5, 0, 1'b0);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("s_ovf_q_const", quotient, 32'h8000_0000);
        run_op("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("busy_ignore", 1'b0, 1000, 7, 1'b1);
        check("busy_ignore_q_const", quotient, 142);

        start = 1'b1;
        is_signed = 1'b0;
        dividend = 32'hFFFF_0000;
        divisor = 3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("after_rst_9_3", 1'b0, 9, 3, 1'b0);

        prev = 0;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = $urandom_range(1, 15);
                2: b = '1;
                3: begin a = 32'h8000_0000; b = $urandom; end
                4: begin a = $urandom_range(0, 200); b = $urandom; end
                default: b = $urandom;
            endcase
            run_op("rand", 1'(($urandom) & 1), a, b, 1'b0);
            if (i > 0 && !ZF) check("throughput", (t_acc - prev) / 10, W + 3);
            prev = t_acc;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
